mem_req_sequencer: RTL and testbench

//  Upstream stage of the 1Kx16 memory: buffers host read/write requests in a small FIFO
//  and issues them one at a time on the memory's valid/WR/addr/data_in port, waiting on ready.

---
 rtl/mem_req_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mem_req_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_sequencer.sv
// Request sequencer for the 1Kx16 memory: queues host reads/writes in a small FIFO
// and issues them one at a time on the memory's valid/ready port, with a timeout abort.
module mem_req_sequencer #(
  parameter int DW      = 16,
  parameter int AW      = 10,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_wr_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          err_o,
  output logic          busy_o,
  output logic          mem_valid_o,
  output logic          mem_WR_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_in_o,
  input  logic          mem_ready_i,
  input  logic [DW-1:0] mem_data_out_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = 8;

  typedef enum logic {IDLE, ISSUE} state_e;

  logic          fifoWr_q   [DEPTH];
  logic [AW-1:0] fifoAddr_q [DEPTH];
  logic [DW-1:0] fifoData_q [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cmdWr_q, cmdWr_d;
  logic [AW-1:0] cmdAddr_q, cmdAddr_d;
  logic [DW-1:0] cmdData_q, cmdData_d;
  logic          memValid_q, memValid_d;
  logic          rdValid_q, rdValid_d;
  logic [DW-1:0] rdData_q, rdData_d;
  logic [AW-1:0] rdAddr_q, rdAddr_d;
  logic          err_q, err_d;
  logic          push, pop;

  // A full FIFO refuses pushes even when the FSM pops in the same cycle.
  assign req_ready_o = (count_q != CW'(DEPTH));
  assign push        = req_valid_i & req_ready_o;
  assign pop         = (state_q == IDLE) && (count_q != '0);

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    state_d    = state_q;
    timer_d    = timer_q;
    cmdWr_d    = cmdWr_q;
    cmdAddr_d  = cmdAddr_q;
    cmdData_d  = cmdData_q;
    memValid_d = memValid_q;
    rdValid_d  = 1'b0;
    rdData_d   = rdData_q;
    rdAddr_d   = rdAddr_q;
    err_d      = 1'b0;

    if (push) wrPtr_d = wrPtr_q + PW'(1);
    if (pop)  rdPtr_d = rdPtr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          cmdWr_d    = fifoWr_q[rdPtr_q];
          cmdAddr_d  = fifoAddr_q[rdPtr_q];
          cmdData_d  = fifoData_q[rdPtr_q];
          memValid_d = 1'b1;
          timer_d    = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // Ready on the final timeout cycle still counts as a normal completion.
        if (mem_ready_i) begin
          memValid_d = 1'b0;
          state_d    = IDLE;
          if (!cmdWr_q) begin
            rdValid_d = 1'b1;
            rdData_d  = mem_data_out_i;
            rdAddr_d  = cmdAddr_q;
          end
        end else if (timer_q == TW'(TIMEOUT)) begin
          memValid_d = 1'b0;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoWr_q[wrPtr_q]   <= req_wr_i;
      fifoAddr_q[wrPtr_q] <= req_addr_i;
      fifoData_q[wrPtr_q] <= req_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      timer_q    <= '0;
      cmdWr_q    <= 1'b0;
      cmdAddr_q  <= '0;
      cmdData_q  <= '0;
      memValid_q <= 1'b0;
      rdValid_q  <= 1'b0;
      rdData_q   <= '0;
      rdAddr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      cmdWr_q    <= cmdWr_d;
      cmdAddr_q  <= cmdAddr_d;
      cmdData_q  <= cmdData_d;
      memValid_q <= memValid_d;
      rdValid_q  <= rdValid_d;
      rdData_q   <= rdData_d;
      rdAddr_q   <= rdAddr_d;
      err_q      <= err_d;
    end
  end

  assign rd_valid_o    = rdValid_q;
  assign rd_data_o     = rdData_q;
  assign rd_addr_o     = rdAddr_q;
  assign err_o         = err_q;
  assign busy_o        = (count_q != '0) || (state_q != IDLE);
  assign mem_valid_o   = memValid_q;
  assign mem_WR_o      = cmdWr_q;
  assign mem_addr_o    = cmdAddr_q;
  assign mem_data_in_o = cmdData_q;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer with a small 1Kx16 memory responder
// that answers one cycle after it sees valid.
module tb_mem_req_sequencer;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 15;

  logic          clk, rstN;
  logic          reqValid, reqReady, reqWr;
  logic [AW-1:0] reqAddr;
  logic [DW-1:0] reqWdata;
  logic          rdValid, err, busy;
  logic [DW-1:0] rdData;
  logic [AW-1:0] rdAddr;
  logic          memValid, memWR, memReady;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memDataIn, memDataOut;

  int errors = 0;
  int checks = 0;

  mem_req_sequencer #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_wr_i(reqWr),
    .req_addr_i(reqAddr), .req_wdata_i(reqWdata),
    .rd_valid_o(rdValid), .rd_data_o(rdData), .rd_addr_o(rdAddr),
    .err_o(err), .busy_o(busy),
    .mem_valid_o(memValid), .mem_WR_o(memWR), .mem_addr_o(memAddr),
    .mem_data_in_o(memDataIn), .mem_ready_i(memReady), .mem_data_out_i(memDataOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unwritten locations read back a recognisable pattern derived from the address.
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return 16'hA000 | {6'b0, a};
  endfunction

  bit            memEn = 1'b0;
  bit            forceReady = 1'b0;
  logic [DW-1:0] forceData = '0;
  logic          memReadyQ = 1'b0;
  logic [DW-1:0] memDataQ = '0;
  logic [DW-1:0] memArr [1024];
  bit            written [1024];

  always @(posedge clk) begin
    memReadyQ <= 1'b0;
    if (memEn && memValid && !memReadyQ) begin
      memReadyQ <= 1'b1;
      if (memWR) begin
        memArr[memAddr]  <= memDataIn;
        written[memAddr] <= 1'b1;
      end else begin
        memDataQ <= written[memAddr] ? memArr[memAddr] : dflt(memAddr);
      end
    end
  end

  assign memReady   = memReadyQ | forceReady;
  assign memDataOut = forceReady ? forceData : memDataQ;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } rd_t;

  rd_t rdQ[$];
  int  errPulses = 0;
  int  gapViol = 0;
  bit  pendDone = 1'b0;

  // Collects read responses and err pulses, and notes any completion not followed by an idle cycle.
  always @(negedge clk) begin
    if (rdValid === 1'b1) rdQ.push_back('{rdAddr, rdData});
    if (err === 1'b1) errPulses++;
    if (pendDone && memValid === 1'b1) gapViol++;
    pendDone = (memValid === 1'b1) && (memReady === 1'b1);
  end

  task automatic pushReq(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output bit ok);
    ok = 1'b0;
    @(negedge clk);
    reqValid = 1'b1;
    reqWr    = wr;
    reqAddr  = a;
    reqWdata = d;
    for (int i = 0; i < 100; i++) begin
      if (reqReady) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 reqValid = 1'b0;
  endtask

  task automatic test_reset;
    rstN = 1'b0; reqValid = 1'b1; reqWr = 1'b0; reqAddr = '0; reqWdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b want 1", reqReady); end
    checks++; if (memValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_valid: got %b want 0", memValid); end
    checks++; if (rdValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %b want 0", rdValid); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    reqValid = 1'b0;
    @(negedge clk) rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    bit ok;
    int acc = 0;
    int g0 = gapViol;
    int e0 = errPulses;
    memEn = 1'b1;
    rdQ.delete();
    pushReq(1'b1, 10'd5, 16'hBEEF, ok);  acc += int'(ok);
    pushReq(1'b1, 10'd35, 16'h1234, ok); acc += int'(ok);
    pushReq(1'b0, 10'd5, 16'h0000, ok);  acc += int'(ok);
    pushReq(1'b0, 10'd35, 16'h0000, ok); acc += int'(ok);
    for (int i = 0; i < 60; i++) begin
      if (rdQ.size() >= 2 && busy === 1'b0) break;
      @(negedge clk);
    end
    checks++; if (acc !== 4) begin errors++; $display("[TB] FAIL wr_accepted: got %0d want 4", acc); end
    checks++; if (rdQ.size() !== 2) begin errors++; $display("[TB] FAIL wr_rd_count: got %0d want 2", rdQ.size()); end
    checks++; if (rdQ[0].d !== 16'hBEEF) begin errors++; $display("[TB] FAIL wr_rd0_data: got %h want beef", rdQ[0].d); end
    checks++; if (rdQ[0].a !== 10'd5) begin errors++; $display("[TB] FAIL wr_rd0_addr: got %0d want 5", rdQ[0].a); end
    checks++; if (rdQ[1].d !== 16'h1234) begin errors++; $display("[TB] FAIL wr_rd1_data: got %h want 1234", rdQ[1].d); end
    checks++; if (rdQ[1].a !== 10'd35) begin errors++; $display("[TB] FAIL wr_rd1_addr: got %0d want 35", rdQ[1].a); end
    checks++; if (gapViol !== g0) begin errors++; $display("[TB] FAIL wr_idle_gap: got %0d violations want 0", gapViol - g0); end
    checks++; if (errPulses !== e0) begin errors++; $display("[TB] FAIL wr_no_err: got %0d err pulses want 0", errPulses - e0); end
  endtask

  task automatic test_full;
    bit ok, ok6;
    int acc = 0;
    int e0 = errPulses;
    logic rdyAfterFill;
    logic [AW-1:0] wantA;
    memEn = 1'b0;
    rdQ.delete();
    for (int i = 0; i < 5; i++) begin
      pushReq(1'b0, AW'(200 + i), '0, ok);
      acc += int'(ok);
    end
    rdyAfterFill = reqReady;
    checks++; if (acc !== 5) begin errors++; $display("[TB] FAIL full_accepted: got %0d want 5", acc); end
    checks++; if (rdyAfterFill !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_low: got %b want 0", rdyAfterFill); end
    fork
      pushReq(1'b0, 10'd205, '0, ok6);
      begin
        repeat (4) @(negedge clk);
        checks++; if (reqReady !== 1'b0) begin errors++; $display("[TB] FAIL full_held: got ready=%b want 0", reqReady); end
        memEn = 1'b1;
      end
    join
    checks++; if (ok6 !== 1'b1) begin errors++; $display("[TB] FAIL full_sixth_accepted: got %b want 1", ok6); end
    checks++; if (rdQ.size() !== 1) begin errors++; $display("[TB] FAIL full_sixth_timing: got %0d reads done want 1", rdQ.size()); end
    for (int i = 0; i < 200; i++) begin
      if (rdQ.size() >= 6 && busy === 1'b0) break;
      @(negedge clk);
    end
    checks++; if (rdQ.size() !== 6) begin errors++; $display("[TB] FAIL full_rd_count: got %0d want 6", rdQ.size()); end
    for (int i = 0; i < 6; i++) begin
      wantA = AW'(200 + i);
      checks++; if (rdQ[i].a !== wantA) begin errors++; $display("[TB] FAIL full_order_addr%0d: got %0d want %0d", i, rdQ[i].a, wantA); end
      checks++; if (rdQ[i].d !== dflt(wantA)) begin errors++; $display("[TB] FAIL full_order_data%0d: got %h want %h", i, rdQ[i].d, dflt(wantA)); end
    end
    checks++; if (errPulses !== e0) begin errors++; $display("[TB] FAIL full_no_err: got %0d err pulses want 0", errPulses - e0); end
  endtask

  task automatic test_timeout;
    bit ok;
    int k = 0;
    int e0 = errPulses;
    logic vAtErr;
    memEn = 1'b0;
    rdQ.delete();
    pushReq(1'b0, 10'd100, '0, ok);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (memValid === 1'b1) break;
    end
    while (err !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    vAtErr = memValid;
    checks++; if (k !== TIMEOUT + 1) begin errors++; $display("[TB] FAIL to_err_delay: got %0d cycles want %0d", k, TIMEOUT + 1); end
    checks++; if (vAtErr !== 1'b0) begin errors++; $display("[TB] FAIL to_valid_drop: got %b want 0", vAtErr); end
    @(negedge clk);
    checks++; if (errPulses !== e0 + 1) begin errors++; $display("[TB] FAIL to_err_pulses: got %0d want 1", errPulses - e0); end
    checks++; if (rdQ.size() !== 0) begin errors++; $display("[TB] FAIL to_no_rd: got %0d reads want 0", rdQ.size()); end
    memEn = 1'b1;
    pushReq(1'b0, 10'd5, '0, ok);
    for (int i = 0; i < 30; i++) begin
      if (rdQ.size() >= 1) break;
      @(negedge clk);
    end
    checks++; if (rdQ[0].d !== 16'hBEEF) begin errors++; $display("[TB] FAIL to_recover_data: got %h want beef", rdQ[0].d); end
    checks++; if (rdQ[0].a !== 10'd5) begin errors++; $display("[TB] FAIL to_recover_addr: got %0d want 5", rdQ[0].a); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_boundary;
    bit ok;
    int e0 = errPulses;
    memEn = 1'b0;
    pushReq(1'b0, 10'd7, '0, ok);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (memValid === 1'b1) break;
    end
    repeat (TIMEOUT) @(negedge clk);
    forceData  = 16'hC0DE;
    forceReady = 1'b1;
    @(negedge clk);
    forceReady = 1'b0;
    checks++; if (rdValid !== 1'b1) begin errors++; $display("[TB] FAIL bnd_rd_valid: got %b want 1", rdValid); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL bnd_err: got %b want 0", err); end
    checks++; if (rdData !== 16'hC0DE) begin errors++; $display("[TB] FAIL bnd_rd_data: got %h want c0de", rdData); end
    checks++; if (rdAddr !== 10'd7) begin errors++; $display("[TB] FAIL bnd_rd_addr: got %0d want 7", rdAddr); end
    repeat (3) @(negedge clk);
    checks++; if (errPulses !== e0) begin errors++; $display("[TB] FAIL bnd_no_err: got %0d err pulses want 0", errPulses - e0); end
  endtask

  task automatic test_async_reset;
    bit ok;
    int e0;
    memEn = 1'b0;
    for (int i = 0; i < 4; i++) pushReq(1'b0, AW'(300 + i), '0, ok);
    @(negedge clk);
    checks++; if (memValid !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre_state: got valid=%b busy=%b want 1 1", memValid, busy); end
    rdQ.delete();
    e0 = errPulses;
    #2 rstN = 1'b0;
    #1;
    checks++; if (memValid !== 1'b0) begin errors++; $display("[TB] FAIL ar_valid_drop: got %b want 0", memValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ar_busy: got %b want 0", busy); end
    checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL ar_fifo_empty: got ready=%b want 1", reqReady); end
    @(negedge clk) rstN = 1'b1;
    memEn = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (rdQ.size() !== 0) begin errors++; $display("[TB] FAIL ar_no_rd: got %0d reads want 0", rdQ.size()); end
    checks++; if (errPulses !== e0) begin errors++; $display("[TB] FAIL ar_no_err: got %0d err pulses want 0", errPulses - e0); end
    checks++; if (busy !== 1'b0 || memValid !== 1'b0) begin errors++; $display("[TB] FAIL ar_idle_after: got busy=%b valid=%b want 0 0", busy, memValid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_full();
    test_timeout();
    test_boundary();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
